// File: rtl/arm_pkg.sv
// Shared types and constants for the SRAM data-memory controller.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package arm_pkg;

    localparam int SRAM_DATA_W = 16;
    localparam int SRAM_ADDR_W = 18;
    // One 32-bit word spans two half-word locations, so the word index is one bit narrower.
    localparam int SRAM_WORD_W = SRAM_ADDR_W - 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LO   = 2'd1,
        HI   = 2'd2,
        DONE = 2'd3
    } sram_state_t;

    // Byte address to 32-bit word index; the subtraction and truncation let the
    // index wrap modulo 2^SRAM_WORD_W instead of faulting on out-of-range addresses.
    function automatic logic [SRAM_WORD_W-1:0] sram_word(input logic [31:0] address,
                                                         input logic [31:0] base);
        return SRAM_WORD_W'((address - base) >> 2);
    endfunction

endpackage

// File: rtl/sram_ctrl.sv
// Multi-cycle MEM-stage controller: each 32-bit load/store becomes two half-word SRAM accesses.
// Latency: 2*SRAM_WAIT+1 cycles from the request being seen in IDLE to ready in DONE.
// Backpressure: ready is low while a request is outstanding; the pipeline freezes on ~ready.
//
// Ports:
//   clk, rst             - single clock, synchronous active-high reset
//   rd_en, wr_en         - load / store request from the MEM stage (both high acts as a store)
//   address, write_data  - byte address and store data, latched when the request is accepted
//   read_data            - registered load result, valid in DONE and held until the next load
//   ready                - combinational, high when no request or when the access is in DONE
//   SRAM_*               - external 16-bit asynchronous SRAM pins; byte/chip/output enables tied low
module sram_ctrl
    import arm_pkg::*;
#(
    parameter int SRAM_WAIT = 2,
    parameter int ADDR_BASE = 1024
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   rd_en,
    input  logic                   wr_en,
    input  logic [31:0]            address,
    input  logic [31:0]            write_data,
    output logic [31:0]            read_data,
    output logic                   ready,
    inout  wire  [SRAM_DATA_W-1:0] SRAM_DQ,
    output logic [SRAM_ADDR_W-1:0] SRAM_ADDR,
    output logic                   SRAM_WE_N,
    output logic                   SRAM_UB_N,
    output logic                   SRAM_LB_N,
    output logic                   SRAM_CE_N,
    output logic                   SRAM_OE_N
);

    localparam int               CNT_W    = (SRAM_WAIT > 1) ? $clog2(SRAM_WAIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SRAM_WAIT - 1);
    // With a single-cycle phase there is no cycle left to assert WE before the hold cycle.
    localparam bit               MULTI    = (SRAM_WAIT > 1);
    localparam logic [31:0]      BASE     = 32'(ADDR_BASE);

    sram_state_t            state;
    logic [CNT_W-1:0]       cnt;
    logic [CNT_W-1:0]       cnt_nxt;
    logic                   phase_last;
    logic                   nxt_last;
    logic [SRAM_WORD_W-1:0] lat_word;
    logic [31:0]            lat_data;
    logic                   lat_wr;
    logic                   dq_oe;
    logic [SRAM_DATA_W-1:0] dq_out;

    assign cnt_nxt    = cnt + CNT_W'(1);
    assign phase_last = (cnt == CNT_LAST);
    assign nxt_last   = (cnt_nxt == CNT_LAST);

    assign ready = ~(rd_en | wr_en) | (state == DONE);

    // The bus is driven for the whole of both phases of a store, including the
    // final WE-high cycle, so data is still valid when the SRAM latches it.
    assign dq_oe   = lat_wr && ((state == LO) || (state == HI));
    assign dq_out  = (state == HI) ? lat_data[31:16] : lat_data[15:0];
    assign SRAM_DQ = dq_oe ? dq_out : {SRAM_DATA_W{1'bz}};

    assign SRAM_UB_N = 1'b0;
    assign SRAM_LB_N = 1'b0;
    assign SRAM_CE_N = 1'b0;
    assign SRAM_OE_N = 1'b0;

    // WE_N is registered, so every branch sets it for the cycle about to start:
    // low on any store cycle that is not the last one of its phase.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            lat_word  <= '0;
            lat_data  <= '0;
            lat_wr    <= 1'b0;
            read_data <= '0;
            SRAM_ADDR <= '0;
            SRAM_WE_N <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (rd_en | wr_en) begin
                        lat_word  <= sram_word(address, BASE);
                        lat_data  <= write_data;
                        lat_wr    <= wr_en;
                        cnt       <= '0;
                        SRAM_ADDR <= {sram_word(address, BASE), 1'b0};
                        SRAM_WE_N <= !(wr_en && MULTI);
                        state     <= LO;
                    end
                end
                LO: begin
                    if (phase_last) begin
                        if (!lat_wr) begin
                            read_data[15:0] <= SRAM_DQ;
                        end
                        cnt       <= '0;
                        SRAM_ADDR <= {lat_word, 1'b1};
                        SRAM_WE_N <= !(lat_wr && MULTI);
                        state     <= HI;
                    end else begin
                        cnt       <= cnt_nxt;
                        SRAM_WE_N <= !(lat_wr && !nxt_last);
                    end
                end
                HI: begin
                    if (phase_last) begin
                        if (!lat_wr) begin
                            read_data[31:16] <= SRAM_DQ;
                        end
                        cnt       <= '0;
                        SRAM_WE_N <= 1'b1;
                        state     <= DONE;
                    end else begin
                        cnt       <= cnt_nxt;
                        SRAM_WE_N <= !(lat_wr && !nxt_last);
                    end
                end
                DONE: begin
                    // Requests present here are taken on the following IDLE cycle.
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
